// File: rtl/l1_mem_arb_pkg.sv
// rtl/l1_mem_arb_pkg.sv - shared types and constants for the L1 refill arbiter
// Purpose: state and owner encodings, line geometry constants, line type.
// Ports: none (package).
package l1_mem_arb_pkg;

    localparam int LINE_W = 128;
    localparam int OFF_W  = 4;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } owner_t;

endpackage

// File: rtl/l1_mem_arbiter_rr_pick2.sv
// rtl/l1_mem_arbiter_rr_pick2.sv - two-way round-robin picker
// Purpose: combinational winner selection for a two-requester shared port.
// Ports:
//   req[1:0]    requests, bit 0 = ICACHE, bit 1 = DCACHE
//   last_owner  previous winner; loses a tie
//   grant       selected owner (meaningful only with grant_valid)
//   grant_valid at least one request present
module rr_pick2
    import l1_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output owner_t     grant,
    output logic       grant_valid
);

    always_comb begin
        grant       = ICACHE;
        grant_valid = |req;
        case (req)
            2'b01:   grant = ICACHE;
            2'b10:   grant = DCACHE;
            2'b11:   grant = (last_owner == ICACHE) ? DCACHE : ICACHE;
            default: grant = ICACHE;
        endcase
    end

endmodule

// File: rtl/l1_mem_arbiter.sv
// rtl/l1_mem_arbiter.sv - shares one line-wide RAM port between icache and dcache
// Purpose: one transaction at a time, round-robin between the two requesters,
//          request latched on acceptance so requesters may drop their signals.
// Ports:
//   clk, RESET                      clock, synchronous active-high reset
//   ic_req_*  / ic_resp_*           icache line-read request / refill response
//   dc_req_*  / dc_resp_*           dcache allocate-read or writeback / response
//   mem_req_* / mem_resp_*          RAM controller request / response
//   busy                            transaction in progress
//   grant_dc                        current or most recent owner is dcache
module l1_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int OFF_W  = 4
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic [LINE_W-1:0] ic_resp_data,
    input  logic              dc_req_valid,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_rw,
    input  logic [LINE_W-1:0] dc_req_wdata,
    output logic              dc_req_ready,
    output logic              dc_resp_valid,
    output logic [LINE_W-1:0] dc_resp_data,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_rw,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data,
    output logic              busy,
    output logic              grant_dc
);

    import l1_mem_arb_pkg::*;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W)'((1 << OFF_W) - 1));

    arb_state_t        state;
    owner_t            last_owner;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata_q;

    owner_t            pick;
    logic              pick_valid;
    logic              accept;

    rr_pick2 u_pick (
        .req         ({dc_req_valid, ic_req_valid}),
        .last_owner  (last_owner),
        .grant       (pick),
        .grant_valid (pick_valid)
    );

    // Readies are gated by RESET so nothing is accepted in the reset cycle.
    assign accept       = (state == IDLE) && !RESET && pick_valid;
    assign ic_req_ready = accept && (pick == ICACHE);
    assign dc_req_ready = accept && (pick == DCACHE);

    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= IDLE;
            last_owner <= ICACHE;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_owner <= pick;
                        if (pick == DCACHE) begin
                            addr_q  <= dc_req_addr & LINE_MASK;
                            rw_q    <= dc_req_rw;
                            wdata_q <= dc_req_wdata;
                        end else begin
                            addr_q  <= ic_req_addr & LINE_MASK;
                            rw_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        // A RAM that answers in the accept cycle skips WAIT.
                        if (mem_resp_valid) begin
                            rdata_q <= rw_q ? '0 : mem_resp_data;
                            state   <= RESPOND;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q <= rw_q ? '0 : mem_resp_data;
                        state   <= RESPOND;
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req_valid = (state == ISSUE);
    assign mem_req_addr  = addr_q;
    assign mem_req_rw    = rw_q;
    assign mem_req_wdata = wdata_q;

    assign ic_resp_valid = (state == RESPOND) && (last_owner == ICACHE);
    assign dc_resp_valid = (state == RESPOND) && (last_owner == DCACHE);
    assign ic_resp_data  = rdata_q;
    assign dc_resp_data  = rdata_q;

    assign busy     = (state != IDLE);
    assign grant_dc = (last_owner == DCACHE);

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb/tb_l1_mem_arbiter.sv - scoreboard bench for l1_mem_arbiter
module tb_l1_mem_arbiter;
    import l1_mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          RESET = 1'b1;
    logic          ic_req_valid = 1'b0;
    logic [AW-1:0] ic_req_addr = '0;
    logic          ic_req_ready;
    logic          ic_resp_valid;
    logic [LW-1:0] ic_resp_data;
    logic          dc_req_valid = 1'b0;
    logic [AW-1:0] dc_req_addr = '0;
    logic          dc_req_rw = 1'b0;
    logic [LW-1:0] dc_req_wdata = '0;
    logic          dc_req_ready;
    logic          dc_resp_valid;
    logic [LW-1:0] dc_resp_data;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_rw;
    logic [LW-1:0] mem_req_wdata;
    logic          mem_req_ready = 1'b0;
    logic          mem_resp_valid = 1'b0;
    logic [LW-1:0] mem_resp_data = '0;
    logic          busy;
    logic          grant_dc;

    l1_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .OFF_W(4)) dut (
        .clk(clk), .RESET(RESET),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_rw(dc_req_rw),
        .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .grant_dc(grant_dc)
    );

    always #5 clk = ~clk;

    typedef struct {
        owner_t        owner;
        logic [AW-1:0] addr;
        logic          rw;
        logic [LW-1:0] wdata;
    } req_t;

    typedef struct {
        owner_t        owner;
        logic [LW-1:0] data;
    } resp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rw;
        logic [LW-1:0] wdata;
    } dreq_t;

    req_t          exp_req_q[$];
    resp_t         exp_resp_q[$];
    logic [AW-1:0] ic_q[$];
    dreq_t         dc_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cyc = -10;
    int resp_sent_cyc = -10;
    int resp_pulses = 0;
    int mem_valid_cycles = 0;

    int            ready_delay = 0;
    int            resp_delay = 1;
    bit            same_cycle = 1'b0;
    int            wait_cnt = 0;
    int            resp_cnt = 0;
    bit            in_txn = 1'b0;
    logic [LW-1:0] rdata = '0;

    // Requester agents, RAM model and scoreboard monitors, all on the falling edge.
    always @(negedge clk) begin : agent
        req_t        e;
        resp_t       r;
        logic        acc;
        logic [1:0]  exp_rdy;
        logic [LW-1:0] got;
        owner_t      got_owner;
        cyc++;
        ic_req_valid = (ic_q.size() > 0);
        ic_req_addr  = ic_req_valid ? ic_q[0] : '0;
        dc_req_valid = (dc_q.size() > 0);
        dc_req_addr  = dc_req_valid ? dc_q[0].addr  : '0;
        dc_req_rw    = dc_req_valid ? dc_q[0].rw    : 1'b0;
        dc_req_wdata = dc_req_valid ? dc_q[0].wdata : '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        acc = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_resp_valid = 1'b1;
                resp_sent_cyc  = cyc;
            end
        end
        if (mem_req_valid) begin
            if (wait_cnt < ready_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt      = 0;
                mem_req_ready = 1'b1;
                acc           = 1'b1;
                if (same_cycle) begin
                    mem_resp_valid = 1'b1;
                    resp_sent_cyc  = cyc;
                end else begin
                    resp_cnt = resp_delay;
                end
            end
        end
        mem_resp_data = rdata;
        #1;
        if (ic_req_valid || dc_req_valid) begin
            checks++;
            if (RESET || busy) begin
                if (ic_req_ready || dc_req_ready)
                    $display("FAIL ready_while_busy actual=%b%b expected=00 cyc=%0d", ic_req_ready, dc_req_ready, cyc);
                if (ic_req_ready || dc_req_ready) failures++;
            end else if (exp_req_q.size() == 0) begin
                failures++;
                $display("FAIL unplanned_request actual=valid expected=none cyc=%0d", cyc);
            end else begin
                exp_rdy = (exp_req_q[0].owner == ICACHE) ? 2'b10 : 2'b01;
                if ({ic_req_ready, dc_req_ready} !== exp_rdy) begin
                    failures++;
                    $display("FAIL grant actual=%b%b expected=%b cyc=%0d", ic_req_ready, dc_req_ready, exp_rdy, cyc);
                end
            end
            if (ic_req_valid && ic_req_ready) begin ic_q.pop_front(); hs_cyc = cyc; end
            if (dc_req_valid && dc_req_ready) begin dc_q.pop_front(); hs_cyc = cyc; end
        end
        if (mem_req_valid) begin
            mem_valid_cycles++;
            checks++;
            if (exp_req_q.size() == 0) begin
                failures++;
                $display("FAIL mem_req_unexpected actual=%h expected=none", mem_req_addr);
            end else begin
                e = exp_req_q[0];
                if (mem_req_addr !== e.addr || mem_req_rw !== e.rw || mem_req_wdata !== e.wdata
                    || grant_dc !== (e.owner == DCACHE)) begin
                    failures++;
                    $display("FAIL mem_req actual=%h/%b/%h/%b expected=%h/%b/%h/%b", mem_req_addr, mem_req_rw,
                             mem_req_wdata, grant_dc, e.addr, e.rw, e.wdata, (e.owner == DCACHE));
                end
                if (!in_txn) begin
                    in_txn = 1'b1;
                    checks++;
                    if (cyc != hs_cyc + 1) begin
                        failures++;
                        $display("FAIL req_latency actual=%0d expected=%0d", cyc, hs_cyc + 1);
                    end
                end
                if (acc) begin
                    void'(exp_req_q.pop_front());
                    in_txn  = 1'b0;
                    r.owner = e.owner;
                    r.data  = e.rw ? '0 : rdata;
                    exp_resp_q.push_back(r);
                end
            end
        end
        if (ic_resp_valid || dc_resp_valid) begin
            resp_pulses++;
            checks++;
            got_owner = dc_resp_valid ? DCACHE : ICACHE;
            got       = dc_resp_valid ? dc_resp_data : ic_resp_data;
            if (ic_resp_valid && dc_resp_valid) begin
                failures++;
                $display("FAIL resp_both actual=11 expected=one-hot");
            end else if (exp_resp_q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected actual=%b%b expected=00 cyc=%0d", ic_resp_valid, dc_resp_valid, cyc);
            end else begin
                r = exp_resp_q.pop_front();
                if (got_owner !== r.owner || got !== r.data || cyc != resp_sent_cyc + 1) begin
                    failures++;
                    $display("FAIL resp actual=%0d/%h@%0d expected=%0d/%h@%0d", got_owner, got, cyc,
                             r.owner, r.data, resp_sent_cyc + 1);
                end
            end
        end
    end

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (exp_req_q.size() == 0 && exp_resp_q.size() == 0 && ic_q.size() == 0
                && dc_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_req_valid, busy, grant_dc} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl actual=%b expected=0000000",
                     {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_req_valid, busy, grant_dc});
        end
        checks++;
        if (mem_req_addr !== '0 || mem_req_rw !== 1'b0 || mem_req_wdata !== '0
            || ic_resp_data !== '0 || dc_resp_data !== '0) begin
            failures++;
            $display("FAIL reset_data actual=%h/%b/%h expected=0", mem_req_addr, mem_req_rw, mem_req_wdata);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        int p0;
        ready_delay = 0; resp_delay = 1; same_cycle = 1'b0;
        rdata = {$urandom, $urandom, $urandom, $urandom};
        dc_q.push_back('{addr: 32'h0000_3004, rw: 1'b0, wdata: '0});
        dc_q.push_back('{addr: 32'h0000_500C, rw: 1'b1, wdata: {4{32'hC0DE_0001}}});
        ic_q.push_back(32'h0000_4008);
        ic_q.push_back(32'h0000_600F);
        exp_req_q.push_back('{owner: DCACHE, addr: 32'h0000_3000, rw: 1'b0, wdata: '0});
        exp_req_q.push_back('{owner: ICACHE, addr: 32'h0000_4000, rw: 1'b0, wdata: '0});
        exp_req_q.push_back('{owner: DCACHE, addr: 32'h0000_5000, rw: 1'b1, wdata: {4{32'hC0DE_0001}}});
        exp_req_q.push_back('{owner: ICACHE, addr: 32'h0000_6000, rw: 1'b0, wdata: '0});
        p0 = resp_pulses;
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL fairness_drain actual=stuck expected=drained"); end
        checks++;
        if (resp_pulses - p0 != 4) begin
            failures++;
            $display("FAIL fairness_pulses actual=%0d expected=4", resp_pulses - p0);
        end
    endtask

    task automatic test_ic_alone();
        bit ok;
        int p0;
        ready_delay = 0; resp_delay = 2; same_cycle = 1'b0;
        rdata = {32{4'hA}};
        p0 = resp_pulses;
        exp_req_q.push_back('{owner: ICACHE, addr: 32'h0000_1230, rw: 1'b0, wdata: '0});
        ic_q.push_back(32'h0000_1234);
        wait_drain(ok);
        checks++;
        if (!ok || resp_pulses - p0 != 1) begin
            failures++;
            $display("FAIL ic_alone actual=%0d pulses expected=1", resp_pulses - p0);
        end
    endtask

    task automatic test_dc_writeback();
        bit ok;
        int p0;
        int v0;
        ready_delay = 3; resp_delay = 1; same_cycle = 1'b0;
        rdata = {4{32'hDEAD_BEEF}};
        p0 = resp_pulses;
        v0 = mem_valid_cycles;
        exp_req_q.push_back('{owner: DCACHE, addr: 32'h0000_2000, rw: 1'b1, wdata: {32{4'h1}}});
        dc_q.push_back('{addr: 32'h0000_2008, rw: 1'b1, wdata: {32{4'h1}}});
        wait_drain(ok);
        checks++;
        if (!ok || resp_pulses - p0 != 1) begin
            failures++;
            $display("FAIL dc_writeback actual=%0d pulses expected=1", resp_pulses - p0);
        end
        checks++;
        if (mem_valid_cycles - v0 != 4) begin
            failures++;
            $display("FAIL dc_hold_cycles actual=%0d expected=4", mem_valid_cycles - v0);
        end
        ready_delay = 0;
    endtask

    task automatic test_same_cycle();
        bit ok;
        int p0;
        ready_delay = 0; same_cycle = 1'b1;
        rdata = {$urandom, $urandom, $urandom, $urandom};
        p0 = resp_pulses;
        exp_req_q.push_back('{owner: ICACHE, addr: 32'h7777_7770, rw: 1'b0, wdata: '0});
        ic_q.push_back(32'h7777_7777);
        wait_drain(ok);
        checks++;
        if (!ok || resp_pulses - p0 != 1) begin
            failures++;
            $display("FAIL same_cycle actual=%0d pulses expected=1", resp_pulses - p0);
        end
        same_cycle = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int p0;
        ready_delay = 0; resp_delay = 6; same_cycle = 1'b0;
        rdata = {$urandom, $urandom, $urandom, $urandom};
        exp_req_q.push_back('{owner: DCACHE, addr: 32'h0000_8000, rw: 1'b0, wdata: '0});
        dc_q.push_back('{addr: 32'h0000_8004, rw: 1'b0, wdata: '0});
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #2;
            if (exp_req_q.size() == 0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL reset_mid_accept actual=pending expected=accepted"); end
        @(negedge clk);
        RESET = 1'b1;
        exp_resp_q.delete();
        p0 = resp_pulses;
        @(negedge clk);
        RESET = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy actual=%b expected=0", busy); end
        repeat (10) @(negedge clk);
        #2;
        checks++;
        if (resp_pulses != p0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_late_resp actual=%0d/%b expected=0/0", resp_pulses - p0, busy);
        end
        resp_delay = 1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int p0;
        ready_delay = 0; resp_delay = 3; same_cycle = 1'b0;
        rdata = {$urandom, $urandom, $urandom, $urandom};
        p0 = resp_pulses;
        exp_req_q.push_back('{owner: DCACHE, addr: 32'h0000_9000, rw: 1'b0, wdata: '0});
        exp_req_q.push_back('{owner: ICACHE, addr: 32'h0000_A000, rw: 1'b0, wdata: '0});
        dc_q.push_back('{addr: 32'h0000_9000, rw: 1'b0, wdata: '0});
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #2;
            if (busy) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_start actual=idle expected=busy"); end
        ic_q.push_back(32'h0000_A004);
        wait_drain(ok);
        checks++;
        if (!ok || resp_pulses - p0 != 2) begin
            failures++;
            $display("FAIL back_to_back actual=%0d pulses expected=2", resp_pulses - p0);
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_ic_alone();
        test_dc_writeback();
        test_same_cycle();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
